// File: rtl/mole_game_pkg.sv
// -----------------------------------------------------------------------------
// mole_game_pkg
// Shared definitions for the mole-game datapath and the 7-segment display
// driver that consumes its outputs.
//   - game_state_e : phase encoding (IDLE=0, PLAYING=1, OVER=2)
//   - LIVES_W / SCORE_W / TIME_W : widths of the display-facing buses
//   - SCORE_MAX : saturation ceiling, also used by the display driver for
//                 leading-digit blanking
//   - sat_add() : width-safe saturating add used for scoring
// -----------------------------------------------------------------------------
package mole_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } game_state_e;

  localparam int LIVES_W   = 2;
  localparam int SCORE_W   = 10;
  localparam int TIME_W    = 7;
  localparam int SCORE_MAX = 999;

  // One bit wider than the score so the carry out of the add is never lost
  // before the comparison against the ceiling.
  localparam int SUM_W = SCORE_W + 1;

  // Saturating add: returns min(base + add, ceiling).
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] base,
    input logic [SUM_W-1:0]   add,
    input logic [SCORE_W-1:0] ceiling
  );
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + add;
    if (sum > {1'b0, ceiling}) begin
      sat_add = ceiling;
    end else begin
      sat_add = sum[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
// Prescaler for the game countdown. Counts enabled cycles modulo
// TICKS_PER_SEC and emits a single-cycle tick on the last cycle of each
// period, so the consumer's registers update on the edge that completes
// the period.
//
// Ports
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (counter -> 0)
//   en_i    : advance the counter this cycle
//   clr_i   : synchronous clear, has priority over en_i
//   tick_o  : high for the cycle whose edge wraps the counter
//   count_o : current counter value (debug visibility)
// -----------------------------------------------------------------------------
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 1000000,
  // Derived; kept as a parameter so count_o can be sized in the port list.
  parameter int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A cleared cycle never ticks, even if the counter happens to sit at LAST.
  assign tick_o  = en_i & ~clr_i & at_last;
  assign count_o = cnt_q;

endmodule

// File: rtl/score_life_keeper.sv
// -----------------------------------------------------------------------------
// score_life_keeper
// Game-state bookkeeping in front of the 8-digit 7-segment display driver.
// Turns hit/miss pulses and a start button into lives, a saturating score,
// a per-second countdown and the game phase. Every output comes straight
// from a register (or a decode of the state register), so there is no
// combinational path from any input to any output.
//
// Event interface: hit and miss are single-cycle pulses with no
// back-pressure; a pulse is consumed on the rising edge that samples it and
// its effect is visible on the outputs immediately after that edge.
// start_btn is a level; only its rising edge (vs. the previous cycle) acts.
//
// Ports
//   clk_1mhz   : 1 MHz system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start_btn  : debounced synchronous start level
//   hit        : pulse, mole hit
//   miss       : pulse, mole missed / wrong hole
//   lives      : remaining lives
//   score      : current score, 0..SCORE_MAX
//   time_left  : seconds remaining
//   playing    : high in PLAYING
//   game_over  : high in OVER
//   dbg_state  : current phase (game_state_e encoding)
// -----------------------------------------------------------------------------
module score_life_keeper
  import mole_game_pkg::*;
#(
  parameter int INIT_LIVES    = 3,
  parameter int SCORE_CEIL    = SCORE_MAX,
  parameter int GAME_SECONDS  = 60,
  parameter int TICKS_PER_SEC = 1000000,
  parameter int COMBO_LEN     = 5,
  parameter int COMBO_BONUS   = 5
) (
  input  logic               clk_1mhz,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               hit,
  input  logic               miss,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  time_left,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         dbg_state
);

  // Combo counter only ever holds 0..COMBO_LEN-1; one extra value of
  // headroom lets combo+1 reach COMBO_LEN without wrapping.
  localparam int COMBO_W = $clog2(COMBO_LEN + 1);
  localparam int TICK_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(INIT_LIVES);
  localparam logic [TIME_W-1:0]  TIME_RST  = TIME_W'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] CEIL      = SCORE_W'(SCORE_CEIL);
  localparam logic [COMBO_W-1:0] COMBO_END = COMBO_W'(COMBO_LEN);
  localparam logic [SUM_W-1:0]   ADD_PLAIN = SUM_W'(1);
  localparam logic [SUM_W-1:0]   ADD_COMBO = SUM_W'(1 + COMBO_BONUS);

  game_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               start_d_q;

  logic               start_edge;
  logic               in_play;
  logic               sec_tick;
  logic [TICK_W-1:0]  tick_count;
  logic [COMBO_W-1:0] combo_next;
  logic               combo_done;
  logic               last_life_lost;
  logic               time_expired;

  assign start_edge = start_btn & ~start_d_q;
  assign in_play    = (state_q == ST_PLAYING);

  // ---------------------------------------------------------------------------
  // Countdown prescaler: runs only while playing and sits at zero otherwise,
  // so every new game starts a full second before the first decrement.
  // ---------------------------------------------------------------------------
  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .CNT_W        (TICK_W)
  ) u_sec_tick (
    .clk_i  (clk_1mhz),
    .rst_ni (rst_n),
    .en_i   (in_play),
    .clr_i  (~in_play),
    .tick_o (sec_tick),
    .count_o(tick_count)
  );

  // Event qualifiers (only meaningful while playing).
  assign combo_next     = combo_q + 1'b1;
  assign combo_done     = (combo_next == COMBO_END);
  assign last_life_lost = miss & (lives_q <= LIVES_W'(1));
  assign time_expired   = sec_tick & (time_q == TIME_W'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Expiry and last-life miss on the same cycle both
  // land in the single PLAYING -> OVER transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (last_life_lost || time_expired) state_d = ST_OVER;
      end
      ST_OVER: begin
        if (start_edge) state_d = ST_PLAYING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pure decode of the state register)
  // ---------------------------------------------------------------------------
  always_comb begin
    playing   = 1'b0;
    game_over = 1'b0;
    case (state_q)
      ST_PLAYING: playing   = 1'b1;
      ST_OVER:    game_over = 1'b1;
      default: begin
        playing   = 1'b0;
        game_over = 1'b0;
      end
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Bookkeeping datapath. A hit is scored (bonus included) before a
  // simultaneous miss clears the combo, so hit+miss nets the points and
  // loses a life on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    lives_d = lives_q;
    score_d = score_q;
    time_d  = time_q;
    combo_d = combo_q;

    if (!in_play) begin
      if (start_edge) begin
        lives_d = LIVES_RST;
        score_d = '0;
        time_d  = TIME_RST;
        combo_d = '0;
      end
    end else begin
      if (hit) begin
        if (combo_done) begin
          score_d = sat_add(score_q, ADD_COMBO, CEIL);
          combo_d = '0;
        end else begin
          score_d = sat_add(score_q, ADD_PLAIN, CEIL);
          combo_d = combo_next;
        end
      end

      if (miss) begin
        combo_d = '0;
        lives_d = (lives_q > LIVES_W'(1)) ? lives_q - 1'b1 : '0;
      end

      if (sec_tick && (time_q != '0)) begin
        time_d = time_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      lives_q   <= LIVES_RST;
      score_q   <= '0;
      time_q    <= TIME_RST;
      combo_q   <= '0;
      start_d_q <= 1'b0;
    end else begin
      lives_q   <= lives_d;
      score_q   <= score_d;
      time_q    <= time_d;
      combo_q   <= combo_d;
      start_d_q <= start_btn;
    end
  end

  assign lives     = lives_q;
  assign score     = score_q;
  assign time_left = time_q;

  // The prescaler count is only observed through tick_o here; it is exposed
  // by the sub-module for debug and intentionally folded away at this level.
  logic unused_tick_count;
  assign unused_tick_count = ^tick_count;

endmodule
